// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding and
// per-program start addresses.
package prog_seq_pkg;

  localparam int unsigned NPROG_MAX = 3;

  // Index 0 is "no program yet" and maps to address 0.
  localparam int unsigned BASE [NPROG_MAX+1] = '{0, 0, 200, 500};

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StLoad,
    StRun,
    StHalted,
    StFinished
  } seq_state_e;

  function automatic int unsigned base_addr(input logic [1:0] idx);
    return BASE[idx];
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Handshake bundle between the program sequencer (master) and the program-counter
// and decoder side (slave). Timeout exists only when SEQ_WATCHDOG_EN is defined.
interface prog_sequencer_if #(
  parameter int unsigned A = 10
);
  logic         Start;
  logic         Halt;
  logic         PcLoad;
  logic [A-1:0] PcLoadAddr;
  logic         PcEn;
  logic [A-1:0] BranchBase;
  logic [1:0]   ProgIdx;
  logic         Ack;
  logic         AllDone;
`ifdef SEQ_WATCHDOG_EN
  logic         Timeout;
`endif

  modport master (
`ifdef SEQ_WATCHDOG_EN
    output Timeout,
`endif
    input  Start, Halt,
    output PcLoad, PcLoadAddr, PcEn, BranchBase, ProgIdx, Ack, AllDone
  );

  modport slave (
`ifdef SEQ_WATCHDOG_EN
    input  Timeout,
`endif
    output Start, Halt,
    input  PcLoad, PcLoadAddr, PcEn, BranchBase, ProgIdx, Ack, AllDone
  );

endinterface

// File: rtl/edge_detect.sv
// Registers a level and flags its rising and falling edges combinationally
// against the registered copy.
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic D,
  output logic Rise,
  output logic Fall
);

  logic d_r;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      d_r <= 1'b0;
    end else begin
      d_r <= D;
    end
  end

  assign Rise = D & ~d_r;
  assign Fall = ~D & d_r;

endmodule

// File: rtl/prog_sequencer.sv
// Steps through a fixed series of programs on Start pulses, loading each start
// address into the PC. Define SEQ_WATCHDOG_EN to add a per-program cycle limit.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned A           = 10,
  parameter int unsigned NPROG       = 3,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input logic               Clk,
  input logic               Reset,
  prog_sequencer_if.master  bus
);

  localparam logic [1:0] LastIdx = 2'(NPROG);

  seq_state_e   state_q, state_d;
  logic [1:0]   prog_idx_q, prog_idx_d;
  logic [A-1:0] branch_base_q, branch_base_d;
  logic [A-1:0] load_addr;
  logic         rise, fall;

  edge_detect u_start_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .D     (bus.Start),
    .Rise  (rise),
    .Fall  (fall)
  );

  assign load_addr = A'(base_addr(prog_idx_q));

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(WDOG_CYCLES) + 1;

  logic [CntW-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
  logic            wdog_hit;

  assign wdog_hit = (wdog_q == CntW'(WDOG_CYCLES - 1));
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      prog_idx_q    <= '0;
      branch_base_q <= '0;
`ifdef SEQ_WATCHDOG_EN
      wdog_q        <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      prog_idx_q    <= prog_idx_d;
      branch_base_q <= branch_base_d;
`ifdef SEQ_WATCHDOG_EN
      wdog_q        <= wdog_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    prog_idx_d    = prog_idx_q;
    branch_base_d = branch_base_q;
`ifdef SEQ_WATCHDOG_EN
    wdog_d        = wdog_q;
    timeout_d     = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          if (prog_idx_q < LastIdx) prog_idx_d = prog_idx_q + 2'd1;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (fall) state_d = StLoad;
      end
      StLoad: begin
        branch_base_d = load_addr;
        state_d       = StRun;
`ifdef SEQ_WATCHDOG_EN
        wdog_d        = '0;
        timeout_d     = 1'b0;
`endif
      end
      StRun: begin
        // Halt beats both a coincident Start rise and the watchdog.
        if (bus.Halt) begin
          state_d = StHalted;
`ifdef SEQ_WATCHDOG_EN
        end else if (wdog_hit) begin
          state_d   = StHalted;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      StHalted: begin
        if (rise) begin
          if (prog_idx_q < LastIdx) begin
            prog_idx_d = prog_idx_q + 2'd1;
            state_d    = StArmed;
          end else begin
            state_d = StFinished;
          end
        end
      end
      StFinished: ;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.PcLoad     = (state_q == StLoad);
    bus.PcLoadAddr = load_addr;
    bus.PcEn       = (state_q == StRun);
    bus.BranchBase = branch_base_q;
    bus.ProgIdx    = prog_idx_q;
    bus.Ack        = (state_q == StHalted);
    bus.AllDone    = (state_q == StFinished);
`ifdef SEQ_WATCHDOG_EN
    bus.Timeout    = timeout_q;
`endif
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: reset, program series, ignored Start edges,
// saturation, mid-run reset and, with SEQ_WATCHDOG_EN, the watchdog.
module tb_prog_sequencer;

  localparam int unsigned A = 10;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  prog_sequencer_if #(.A(A)) bus ();

  prog_sequencer #(
    .A           (A),
    .NPROG       (3),
    .WDOG_CYCLES (16)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Start 0->1->0 from IDLE/HALTED, ending in the first RUN cycle.
  task automatic pulse_to_run();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
  endtask

  int pcload_seen;
  int pcen_seen;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.Halt  = 1'b0;
    do_reset();

    check("rst_progidx", bus.ProgIdx, 0);
    check("rst_pcen", bus.PcEn, 0);
    check("rst_pcload", bus.PcLoad, 0);
    check("rst_ack", bus.Ack, 0);
    check("rst_alldone", bus.AllDone, 0);
    check("rst_bbase", bus.BranchBase, 0);
    check("rst_loadaddr", bus.PcLoadAddr, 0);

    // Idle with Start low: nothing moves.
    pcload_seen = 0;
    pcen_seen   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pcload_seen += int'(bus.PcLoad);
      pcen_seen   += int'(bus.PcEn);
    end
    check("idle_pcload_cnt", pcload_seen, 0);
    check("idle_pcen_cnt", pcen_seen, 0);
    check("idle_progidx", bus.ProgIdx, 0);

    // Program 1.
    bus.Start = 1'b1;
    tick();
    check("p1_armed_idx", bus.ProgIdx, 1);
    check("p1_armed_pcload", bus.PcLoad, 0);
    bus.Start = 1'b0;
    tick();
    check("p1_load_pcload", bus.PcLoad, 1);
    check("p1_load_addr", bus.PcLoadAddr, 0);
    check("p1_load_pcen", bus.PcEn, 0);
    tick();
    check("p1_run_pcload", bus.PcLoad, 0);
    check("p1_run_pcen", bus.PcEn, 1);
    check("p1_run_bbase", bus.BranchBase, 0);

    // Start edges during RUN are ignored.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    check("run_ign_idx", bus.ProgIdx, 1);
    check("run_ign_pcload", bus.PcLoad, 0);
    check("run_ign_pcen", bus.PcEn, 1);

    bus.Halt = 1'b1;
    tick();
    bus.Halt = 1'b0;
    check("p1_halt_ack", bus.Ack, 1);
    check("p1_halt_pcen", bus.PcEn, 0);
    tick();
    tick();
    check("p1_ack_held", bus.Ack, 1);

    // Program 2.
    bus.Start = 1'b1;
    tick();
    check("p2_ack_clr", bus.Ack, 0);
    check("p2_idx", bus.ProgIdx, 2);
    bus.Start = 1'b0;
    tick();
    check("p2_pcload", bus.PcLoad, 1);
    check("p2_load_addr", bus.PcLoadAddr, 200);
    tick();
    check("p2_bbase", bus.BranchBase, 200);
    check("p2_pcen", bus.PcEn, 1);

    // Halt together with a Start rise: Halt wins, rise is lost.
    bus.Halt  = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Halt = 1'b0;
    check("hs_ack", bus.Ack, 1);
    check("hs_idx", bus.ProgIdx, 2);
    bus.Start = 1'b0;
    tick();
    check("hs_ack_after_fall", bus.Ack, 1);
    check("hs_idx_after_fall", bus.ProgIdx, 2);

    // Program 3.
    bus.Start = 1'b1;
    tick();
    check("p3_idx", bus.ProgIdx, 3);
    bus.Start = 1'b0;
    tick();
    check("p3_load_addr", bus.PcLoadAddr, 500);
    check("p3_pcload", bus.PcLoad, 1);
    tick();
    check("p3_bbase", bus.BranchBase, 500);
    bus.Halt = 1'b1;
    tick();
    bus.Halt = 1'b0;
    check("p3_ack", bus.Ack, 1);

    // Fourth rise finishes the series.
    bus.Start = 1'b1;
    tick();
    check("fin_alldone", bus.AllDone, 1);
    check("fin_pcen", bus.PcEn, 0);
    check("fin_ack", bus.Ack, 0);
    bus.Start = 1'b0;
    tick();
    pulse_to_run();
    check("fin_sat_idx", bus.ProgIdx, 3);
    check("fin_terminal", bus.AllDone, 1);
    check("fin_no_pcload", bus.PcLoad, 0);

    // Reset mid-run.
    do_reset();
    pulse_to_run();
    check("mr_pcen_pre", bus.PcEn, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_pcen", bus.PcEn, 0);
    check("mr_idx", bus.ProgIdx, 0);
    check("mr_bbase", bus.BranchBase, 0);
    check("mr_ack", bus.Ack, 0);
    check("mr_alldone", bus.AllDone, 0);
    check("mr_pcload", bus.PcLoad, 0);
    pulse_to_run();
    check("mr_restart_idx", bus.ProgIdx, 1);
    check("mr_restart_pcen", bus.PcEn, 1);

`ifdef SEQ_WATCHDOG_EN
    // No Halt: forced out after 16 RUN cycles.
    do_reset();
    pulse_to_run();
    for (int i = 0; i < 15; i++) tick();
    check("wd_c16_pcen", bus.PcEn, 1);
    check("wd_c16_timeout", bus.Timeout, 0);
    tick();
    check("wd_timeout", bus.Timeout, 1);
    check("wd_ack", bus.Ack, 1);
    check("wd_pcen", bus.PcEn, 0);
    // Halt on cycle 16 wins over the watchdog.
    pulse_to_run();
    check("wd_p2_timeout_clr", bus.Timeout, 0);
    for (int i = 0; i < 15; i++) tick();
    bus.Halt = 1'b1;
    tick();
    bus.Halt = 1'b0;
    check("wd_halt_timeout", bus.Timeout, 0);
    check("wd_halt_ack", bus.Ack, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
